// File: rtl/fq_pkg.sv
// Shared constants, entry layout and parameter checks for the fetch queue.
// Optional same-cycle bypass is enabled by defining FQ_BYPASS_EN.
package fq_pkg;

    localparam int          PC_INC    = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } fq_entry_t;

    function automatic bit depth_ok(input int d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH x W registers, one write port, async read.
// Cleared on reset so the head reads as zero until first written.
module fetch_queue_mem
    import fq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling fetch front end: owns the PC, queues {pc+4, instr} for ID.
// Define FQ_BYPASS_EN for a zero-latency path when the queue is empty.
module fetch_queue
    import fq_pkg::*;
#(
    parameter int               DATA_W   = 32,
    parameter int               ADDR_W   = 32,
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [DATA_W-1:0]        imem_data,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [DATA_W-1:0]        id_instr,
    output logic [ADDR_W-1:0]        id_pc,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int IW = $clog2(DEPTH);
    localparam int EW = ADDR_W + DATA_W;

    if (!depth_ok(DEPTH)) begin : g_depth_chk
        $error("fetch_queue: DEPTH must be a power of 2 and >= 2");
    end

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next4;
    logic [IW:0]       wr_ptr;
    logic [IW:0]       rd_ptr;
    logic              empty;
    logic              full;
    logic              byp;
    logic              q_deq;
    logic              fetch;
    logic              wr_en;
    logic [EW-1:0]     head;

    assign pc_next4 = pc + ADDR_W'(PC_INC);
    assign imem_addr = pc;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) &&
                   (wr_ptr[IW] != rd_ptr[IW]);

`ifdef FQ_BYPASS_EN
    assign byp = empty && !redirect;
`else
    assign byp = 1'b0;
`endif

    assign q_deq = !empty && id_ready;
    assign fetch = !redirect && (!full || q_deq);
    // A fetch consumed directly by ID through the bypass never lands in storage
    assign wr_en = fetch && !(byp && id_ready);

    assign id_valid = !empty || byp;
    assign id_instr = byp ? imem_data : head[DATA_W-1:0];
    assign id_pc    = byp ? pc_next4  : head[EW-1:DATA_W];
    assign fq_count = wr_ptr - rd_ptr;

    fetch_queue_mem #(
        .DEPTH(DEPTH),
        .W    (EW)
    ) u_mem (
        .clk  (clk),
        .reset(reset),
        .we   (wr_en),
        .waddr(wr_ptr[IW-1:0]),
        .wdata({pc_next4, imem_data}),
        .raddr(rd_ptr[IW-1:0]),
        .rdata(head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (redirect) begin
            pc     <= redirect_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fetch) pc <= pc_next4;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (q_deq) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, DEPTH=4, RESET_PC=0).
// Instruction memory returns its address as data.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [2:0]  fq_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_data = imem_addr;

    fetch_queue #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .DEPTH   (4),
        .RESET_PC(32'h0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_ready   (id_ready),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .fq_count   (fq_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b1;
        #2;
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_count", 32'(fq_count), 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        #6;
        reset = 1'b0;
        #1;
        chk("lat_valid0", 32'(id_valid), 32'd0);

        // streaming with ID always ready
        step();
        chk("run_valid", 32'(id_valid), 32'd1);
        chk("run_pc4", id_pc, 32'd4);
        chk("run_instr0", id_instr, 32'd0);
        step();
        chk("run_pc8", id_pc, 32'd8);
        step();
        chk("run_pc12", id_pc, 32'd12);
        chk("run_instr8", id_instr, 32'd8);
        chk("run_addr12", imem_addr, 32'd12);
        chk("run_count1", 32'(fq_count), 32'd1);

        // fresh start, ID stalled for 6 cycles
        reset    = 1'b1;
        id_ready = 1'b0;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("stall_count%0d", i), 32'(fq_count),
                (i < 4) ? 32'(i + 1) : 32'd4);
        end
        chk("stall_addr", imem_addr, 32'd16);
        chk("stall_head", id_pc, 32'd4);

        // release: full queue, enq+deq every cycle
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_pc%0d", i), id_pc, 32'(4 * (i + 1)));
            chk($sformatf("drain_in%0d", i), id_instr, 32'(4 * i));
            chk($sformatf("drain_cnt%0d", i), 32'(fq_count), 32'd4);
            step();
        end
        chk("drain_addr", imem_addr, 32'd48);

        // redirect with a dequeue while full
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        id_ready = 1'b0;
        chk("rdq_count", 32'(fq_count), 32'd0);
        chk("rdq_valid", 32'(id_valid), 32'd0);
        chk("rdq_addr", imem_addr, 32'h200);
        step();
        chk("rdq_count1", 32'(fq_count), 32'd1);
        chk("rdq_pc", id_pc, 32'h204);
        chk("rdq_instr", id_instr, 32'h200);
        step();
        step();
        chk("pre_rd_count", 32'(fq_count), 32'd3);
        chk("pre_rd_addr", imem_addr, 32'h20C);

        // redirect while count=3
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("rd_count", 32'(fq_count), 32'd0);
        chk("rd_valid", 32'(id_valid), 32'd0);
        chk("rd_addr", imem_addr, 32'h100);
        step();
        chk("rd_valid1", 32'(id_valid), 32'd1);
        chk("rd_pc", id_pc, 32'h104);
        chk("rd_count1", 32'(fq_count), 32'd1);

        // PC wrap at top of address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        id_ready    = 1'b1;
        step();
        redirect = 1'b0;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc", id_pc, 32'h0);
        chk("wrap_instr", id_instr, 32'hFFFF_FFFC);
        chk("wrap_addr1", imem_addr, 32'h0);

        // async reset on a stalled full queue
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("full_count", 32'(fq_count), 32'd4);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(id_valid), 32'd0);
        chk("arst_count", 32'(fq_count), 32'd0);
        chk("arst_pc", id_pc, 32'd0);
        chk("arst_instr", id_instr, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        #2;
        reset = 1'b0;
        chk("rel_addr", imem_addr, 32'd0);
        step();
        chk("rel_count", 32'(fq_count), 32'd1);
        chk("rel_pc", id_pc, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
